// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI read controller among NUM_REQ requesters.
// Optional error masking of failing requesters is enabled with `define ARB_ERR_MASK_EN.
module axi_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       dn_valid,
    output logic [ADDR_W-1:0]          dn_addr,
    input  logic [DATA_W-1:0]          dn_data,
    input  logic                       dn_ready,
    input  logic                       dn_err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    input  logic [NUM_REQ-1:0]         err_clr,
    output logic [NUM_REQ-1:0]         err_mask
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Handshake: req_valid is held until a one-cycle req_ack; dn_valid is a one-cycle
    // command pulse and dn_ready a one-cycle response pulse accepted only in WAIT.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t              state, state_d;
    logic [ID_W-1:0]     ptr, ptr_d;
    logic [1:0]          gap_cnt, gap_d;
    logic [ID_W-1:0]     grant_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                dn_valid_d, rsp_err_d, busy_d;
    logic [NUM_REQ-1:0]  ack_d, rsp_valid_d, mask_set, eligible;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                found_hi;
    logic [ID_W-1:0]     pick_hi, pick_lo, pick;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    assign eligible = req_valid & ~err_mask;

    // Lowest eligible index at or above ptr, otherwise lowest overall (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_lo = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    found_hi = 1'b1;
                    pick_hi  = ID_W'(i);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        state_d     = state;
        gap_d       = gap_cnt;
        ptr_d       = ptr;
        grant_d     = grant_id;
        addr_d      = dn_addr;
        dn_valid_d  = 1'b0;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data;
        rsp_err_d   = 1'b0;
        mask_set    = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_d     = ISSUE;
                    grant_d     = pick;
                    ptr_d       = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    addr_d      = addr_arr[pick];
                    dn_valid_d  = 1'b1;
                    ack_d[pick] = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (dn_ready) begin
                    state_d               = GAP;
                    gap_d                 = 2'd2;
                    rsp_valid_d[grant_id] = 1'b1;
                    rsp_data_d            = dn_data;
                    rsp_err_d             = dn_err;
                    mask_set[grant_id]    = dn_err;
                end
            end
            GAP: begin
                // Gives the controller time to finish its post-error fault cycle.
                gap_d = gap_cnt - 2'd1;
                if (gap_cnt == 2'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            ptr       <= '0;
            grant_id  <= '0;
            dn_addr   <= '0;
            dn_valid  <= 1'b0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            gap_cnt   <= gap_d;
            ptr       <= ptr_d;
            grant_id  <= grant_d;
            dn_addr   <= addr_d;
            dn_valid  <= dn_valid_d;
            req_ack   <= ack_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
        end
    end

`ifdef ARB_ERR_MASK_EN
    logic [NUM_REQ-1:0] mask_q;

    // A set on the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else        mask_q <= (mask_q & ~err_clr) | mask_set;
    end

    assign err_mask = mask_q;
`else
    logic unused_mask;

    assign err_mask    = '0;
    assign unused_mask = ^{err_clr, mask_set};
`endif

endmodule
